mdu_ctrl: RTL and testbench
===========================

Name: mdu_ctrl

Overview:
- Multi-cycle multiply/divide unit with sequencing controller for the pipelined MIPS core.
- Accepts mult/multu/div/divu/mthi/mtlo issued from EX.
- Models latency with a busy counter and owns the HI/LO registers.
- Produces the decode-stage stall for any instruction that touches HI/LO while an operation is in flight.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (>=1)
- DIV_CYCLES, 10, busy cycles for div/divu (>=1)

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-low reset
- start  input  1  issue strobe for op this cycle
- op  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (ignored)
- a  input  32  rs operand
- b  input  32  rt operand
- use_md_d  input  1  instruction in D is mult/multu/div/divu/mfhi/mflo/mthi/mtlo
- busy  output  1  operation in flight
- stall  output  1  combinational: use_md_d & (busy | (start & op in 1..4))
- hi  output  32  HI register
- lo  output  32  LO register

Behaviour:
- Reset: taken at the clk edge when reset==0. Sets busy=0, hi=0, lo=0, counter=0, state IDLE, pending results cleared. A reset during an operation aborts it; HI/LO are not updated.
- States:
  - IDLE: busy=0.
  - RUN: busy=1.
- IDLE, start & op 1..4 at edge t:
  - Compute the result from a/b and latch it into pending_hi/pending_lo.
  - Load counter = MULT_CYCLES or DIV_CYCLES.
  - Go to RUN. busy=1 from cycle t+1.
- RUN:
  - Counter decrements each edge.
  - On the edge where counter==1: hi<=pending_hi, lo<=pending_lo, busy<=0, go to IDLE.
  - busy is high for exactly N cycles. New HI/LO are visible the same cycle busy drops.
- IDLE, start & op 5: hi<=a at the edge. op 6: lo<=a. No busy.
- start while busy: ignored entirely, no state or HI/LO change. The upstream stall guarantees this does not happen.
- Back-to-back issue: start in the first IDLE cycle after completion is accepted.
- hi/lo are registered and always readable. A read during RUN returns the old values.
- mult: signed 32x32 -> 64; hi = [63:32], lo = [31:0]. multu: same, unsigned.
- div:
  - lo = quotient, truncated toward zero; hi = remainder, sign of dividend.
  - 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- divu: unsigned quotient/remainder.
- Divide by zero (b==0): full DIV_CYCLES busy period; at completion hi/lo are left unchanged.
- op 0/7 with start: ignored.

Optional Feature:
- Macro MDU_FLUSH_EN.
- When defined:
  - Adds input flush (1 bit), for exception/flush of the issuing instruction.
  - flush==1 at an edge in RUN: go to IDLE, busy=0, pending results discarded, hi/lo unchanged.
  - flush==1 in IDLE together with start: the start is ignored.
  - reset has priority over flush.
- When undefined: no flush port; operations always run to completion.

Test Plan:
- mult a=0xFFFFFFFF, b=2 -> busy high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFE. Repeat as multu -> hi=0x00000001, lo=0xFFFFFFFE.
- div a=0xFFFFFFF9 (-7), b=2 -> busy 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu a=7, b=2 -> lo=3, hi=1. div 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- mthi a=0x1234, then mtlo a=0x5678 on consecutive cycles -> hi=0x1234, lo=0x5678, busy never asserted. div b=0 -> busy 10 cycles, hi/lo stay 0x1234/0x5678.
- Stall:
  - start mult with use_md_d=1 -> stall=1 in the issue cycle and all 5 busy cycles, 0 the cycle after.
  - use_md_d=0 during busy -> stall=0.
  - start during busy -> hi/lo/counter unaffected.
- reset driven 0 in cycle 3 of a div -> next cycle busy=0, hi=lo=0; a subsequent mult completes normally.
- With MDU_FLUSH_EN: flush in cycle 2 of a mult -> busy=0 next cycle, hi/lo unchanged. Without it, the same stimulus (no flush port) completes after 5 cycles.

Source files
------------

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multi-cycle multiply/divide sequencer that owns HI/LO and raises the decode stall.
// Define MDU_FLUSH_EN to add a flush input that aborts an in-flight operation.
module mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        use_md_d,
`ifdef MDU_FLUSH_EN
    input  logic        flush,
`endif
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO  = CW'(0);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Full-width product; sign extension to 64 bits keeps the low 64 bits exact for both signednesses.
    function automatic logic [63:0] mul64(input logic [31:0] x, input logic [31:0] y, input logic sgn);
        logic [63:0] xe;
        logic [63:0] ye;
        xe = sgn ? {{32{x[31]}}, x} : {32'd0, x};
        ye = sgn ? {{32{y[31]}}, y} : {32'd0, y};
        return xe * ye;
    endfunction

    // Returns {remainder, quotient}; signed case divides magnitudes so 0x80000000 / -1 wraps to 0x80000000.
    function automatic logic [63:0] div64(input logic [31:0] x, input logic [31:0] y, input logic sgn);
        logic        xn;
        logic        yn;
        logic [31:0] xm;
        logic [31:0] ym;
        logic [31:0] q;
        logic [31:0] r;
        xn = sgn & x[31];
        yn = sgn & y[31];
        xm = xn ? (32'd0 - x) : x;
        ym = yn ? (32'd0 - y) : y;
        if (ym == 32'd0) begin
            q = 32'd0;
            r = 32'd0;
        end else begin
            q = xm / ym;
            r = xm % ym;
        end
        if (xn ^ yn) begin
            q = 32'd0 - q;
        end else begin
            q = q;
        end
        if (xn) begin
            r = 32'd0 - r;
        end else begin
            r = r;
        end
        return {r, q};
    endfunction

    state_t        state_r;
    state_t        state_s;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_s;
    logic [31:0]   phi_r;
    logic [31:0]   phi_s;
    logic [31:0]   plo_r;
    logic [31:0]   plo_s;
    logic          pwr_r;
    logic          pwr_s;
    logic [31:0]   hi_r;
    logic [31:0]   hi_s;
    logic [31:0]   lo_r;
    logic [31:0]   lo_s;
    logic          busy_r;
    logic          flush_s;
    logic          is_md_s;
    logic [63:0]   mul_res_s;
    logic [63:0]   div_res_s;

`ifdef MDU_FLUSH_EN
    assign flush_s = flush;
`else
    assign flush_s = 1'b0;
`endif

    assign is_md_s   = (op >= 3'd1) && (op <= 3'd4);
    assign mul_res_s = mul64(a, b, op == 3'd1);
    assign div_res_s = div64(a, b, op == 3'd3);

    // Next-state, counter and HI/LO update logic.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        phi_s   = phi_r;
        plo_s   = plo_r;
        pwr_s   = pwr_r;
        hi_s    = hi_r;
        lo_s    = lo_r;
        case (state_r)
            IDLE: begin
                if (start && !flush_s) begin
                    case (op)
                        3'd1, 3'd2: begin
                            state_s        = RUN;
                            cnt_s          = MULT_LOAD;
                            {phi_s, plo_s} = mul_res_s;
                            pwr_s          = 1'b1;
                        end
                        3'd3, 3'd4: begin
                            state_s        = RUN;
                            cnt_s          = DIV_LOAD;
                            {phi_s, plo_s} = div_res_s;
                            // divide by zero still occupies the unit but leaves HI/LO alone
                            pwr_s          = (b != 32'd0);
                        end
                        3'd5: hi_s = a;
                        3'd6: lo_s = a;
                        default: begin
                            state_s = IDLE;
                        end
                    endcase
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (flush_s) begin
                    state_s = IDLE;
                    cnt_s   = CNT_ZERO;
                    phi_s   = 32'd0;
                    plo_s   = 32'd0;
                    pwr_s   = 1'b0;
                end else if (cnt_r == CNT_ONE) begin
                    state_s = IDLE;
                    cnt_s   = CNT_ZERO;
                    if (pwr_r) begin
                        hi_s = phi_r;
                        lo_s = plo_r;
                    end else begin
                        hi_s = hi_r;
                    end
                end else begin
                    cnt_s = cnt_r - CNT_ONE;
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = CNT_ZERO;
            end
        endcase
    end

    // State, counter, pending result and architectural HI/LO registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= IDLE;
            cnt_r   <= CNT_ZERO;
            phi_r   <= 32'd0;
            plo_r   <= 32'd0;
            pwr_r   <= 1'b0;
            hi_r    <= 32'd0;
            lo_r    <= 32'd0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            phi_r   <= phi_s;
            plo_r   <= plo_s;
            pwr_r   <= pwr_s;
            hi_r    <= hi_s;
            lo_r    <= lo_s;
            busy_r  <= (state_s == RUN);
        end
    end

    assign busy  = busy_r;
    assign hi    = hi_r;
    assign lo    = lo_r;
    assign stall = use_md_d & (busy_r | (start & is_md_s));

endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: directed test-plan cases followed by randomized traffic
// checked against an arithmetic reference model.
module tb_mdu_ctrl;
    localparam int MC = 5;
    localparam int DC = 10;
`ifdef MDU_FLUSH_EN
    localparam bit FLUSH_ON = 1'b1;
`else
    localparam bit FLUSH_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        use_md_d;
`ifdef MDU_FLUSH_EN
    logic        flush;
`endif
    logic        busy;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;

    mdu_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .use_md_d(use_md_d),
`ifdef MDU_FLUSH_EN
        .flush(flush),
`endif
        .busy(busy), .stall(stall), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          len;
        bit          has_lit;
        logic [31:0] lhi;
        logic [31:0] llo;
    } exp_t;

    exp_t        sb_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    bit          mon_en = 1'b0;
    bit          done = 1'b0;
    logic        exp_busy = 1'b0;
    logic        exp_stall = 1'b0;
    logic [31:0] exp_hi = 32'd0;
    logic [31:0] exp_lo = 32'd0;

    // reference model state
    int          m_left = 0;
    int          m_n = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;
    logic [31:0] m_phi = 32'd0;
    logic [31:0] m_plo = 32'd0;
    bit          m_pwr = 1'b0;
    bit          nxt_lit = 1'b0;
    logic [31:0] nxt_lhi = 32'd0;
    logic [31:0] nxt_llo = 32'd0;

    function automatic logic [63:0] ref_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        longint          sx;
        longint          sy;
        longint          sq;
        longint          sr;
        longint unsigned ux;
        longint unsigned uy;
        logic [63:0]     res;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'd0, x};
        uy = {32'd0, y};
        case (o)
            3'd1: res = sx * sy;
            3'd2: res = ux * uy;
            3'd3: begin
                sq  = sx / sy;
                sr  = sx % sy;
                res = {sr[31:0], sq[31:0]};
            end
            3'd4: res = {x % y, x / y};
            default: res = 64'd0;
        endcase
        return res;
    endfunction

    function automatic logic [31:0] pick();
        logic [31:0] v;
        case ($urandom_range(0, 5))
            0: v = 32'd0;
            1: v = 32'hFFFF_FFFF;
            2: v = 32'h8000_0000;
            3: v = $urandom_range(0, 15);
            default: v = $urandom();
        endcase
        return v;
    endfunction

    task automatic set_lit(input logic [31:0] h, input logic [31:0] l);
        nxt_lit = 1'b1;
        nxt_lhi = h;
        nxt_llo = l;
    endtask

    // one clock cycle: drive inputs, publish expectations, then advance the model at the edge
    task automatic step(input logic r, input logic s, input logic [2:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic u, input logic f);
        exp_t        e;
        logic [63:0] res;
        bit          fl;
        fl       = f && FLUSH_ON;
        reset    = r;
        start    = s;
        op       = o;
        a        = x;
        b        = y;
        use_md_d = u;
`ifdef MDU_FLUSH_EN
        flush    = f;
`endif
        exp_busy  = (m_left > 0);
        exp_stall = u && ((m_left > 0) || (s && o >= 3'd1 && o <= 3'd4));
        exp_hi    = m_hi;
        exp_lo    = m_lo;
        @(posedge clk);
        if (!r) begin
            if (m_left > 0) begin
                e         = sb_q.pop_back();
                e.hi      = 32'd0;
                e.lo      = 32'd0;
                e.len     = m_n - m_left + 1;
                e.has_lit = 1'b0;
                sb_q.push_back(e);
            end
            m_left = 0;
            m_hi   = 32'd0;
            m_lo   = 32'd0;
        end else if (m_left > 0) begin
            if (fl) begin
                e         = sb_q.pop_back();
                e.hi      = m_hi;
                e.lo      = m_lo;
                e.len     = m_n - m_left + 1;
                e.has_lit = 1'b0;
                sb_q.push_back(e);
                m_left = 0;
            end else if (m_left == 1) begin
                if (m_pwr) begin
                    m_hi = m_phi;
                    m_lo = m_plo;
                end
                m_left = 0;
            end else begin
                m_left = m_left - 1;
            end
        end else if (s && !fl) begin
            if (o >= 3'd1 && o <= 3'd4) begin
                m_n    = (o <= 3'd2) ? MC : DC;
                m_left = m_n;
                m_pwr  = !(o >= 3'd3 && y == 32'd0);
                res    = m_pwr ? ref_op(o, x, y) : 64'd0;
                m_phi  = res[63:32];
                m_plo  = res[31:0];
                e.hi      = m_pwr ? m_phi : m_hi;
                e.lo      = m_pwr ? m_plo : m_lo;
                e.len     = m_n;
                e.has_lit = nxt_lit;
                e.lhi     = nxt_lhi;
                e.llo     = nxt_llo;
                sb_q.push_back(e);
            end else if (o == 3'd5) begin
                m_hi = x;
            end else if (o == 3'd6) begin
                m_lo = x;
            end
        end
        nxt_lit = 1'b0;
        #1;
    endtask

    task automatic idle(input int n, input logic u);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 3'd0, 32'd0, 32'd0, u, 1'b0);
    endtask

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, want, $time);
        end
    endtask

    int   run = 0;
    logic prev_busy = 1'b0;
    exp_t me;

    // monitor: per-cycle output checks plus scoreboard pop when an operation ends
    always @(negedge clk) begin
        if (mon_en) begin
            chk32("busy", {31'd0, busy}, {31'd0, exp_busy});
            chk32("stall", {31'd0, stall}, {31'd0, exp_stall});
            chk32("hi", hi, exp_hi);
            chk32("lo", lo, exp_lo);
            if (busy === 1'b1) begin
                run++;
            end else if (prev_busy === 1'b1) begin
                if (sb_q.size() == 0) begin
                    chk32("sb_underflow", 32'd1, 32'd0);
                end else begin
                    me = sb_q.pop_front();
                    chk32("done_hi", hi, me.hi);
                    chk32("done_lo", lo, me.lo);
                    chk32("busy_len", 32'(run), 32'(me.len));
                    if (me.has_lit) begin
                        chk32("plan_hi", hi, me.lhi);
                        chk32("plan_lo", lo, me.llo);
                    end
                end
                run = 0;
            end
            prev_busy = busy;
            if (done) begin
                chk32("sb_drain", 32'(sb_q.size()), 32'd0);
                $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
                $finish;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish, vectors %0d", n_vec);
        $fatal(1, "timeout");
    end

    initial begin
        step(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        mon_en = 1'b1;
        step(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        idle(1, 1'b0);

        set_lit(32'hFFFF_FFFF, 32'hFFFF_FFFE);
        step(1'b1, 1'b1, 3'd1, 32'hFFFF_FFFF, 32'd2, 1'b1, 1'b0);
        idle(MC + 1, 1'b1);
        set_lit(32'h0000_0001, 32'hFFFF_FFFE);
        step(1'b1, 1'b1, 3'd2, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0);
        idle(MC + 1, 1'b0);

        set_lit(32'hFFFF_FFFF, 32'hFFFF_FFFD);
        step(1'b1, 1'b1, 3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
        idle(DC + 1, 1'b0);
        set_lit(32'd1, 32'd3);
        step(1'b1, 1'b1, 3'd4, 32'd7, 32'd2, 1'b0, 1'b0);
        idle(DC + 1, 1'b0);
        set_lit(32'd0, 32'h8000_0000);
        step(1'b1, 1'b1, 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        idle(DC + 1, 1'b0);

        step(1'b1, 1'b1, 3'd5, 32'h1234, 32'd0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 3'd6, 32'h5678, 32'd0, 1'b0, 1'b0);
        idle(2, 1'b0);
        set_lit(32'h1234, 32'h5678);
        step(1'b1, 1'b1, 3'd3, 32'd5, 32'd0, 1'b0, 1'b0);
        idle(DC + 1, 1'b0);

        // starts while busy must be ignored
        set_lit(32'd0, 32'd12);
        step(1'b1, 1'b1, 3'd1, 32'd3, 32'd4, 1'b1, 1'b0);
        step(1'b1, 1'b1, 3'd5, 32'hDEAD, 32'd0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 3'd3, 32'd100, 32'd3, 1'b1, 1'b0);
        idle(MC, 1'b0);

        // reset in the third busy cycle of a divide, then a clean multiply
        step(1'b1, 1'b1, 3'd3, 32'd100, 32'd7, 1'b0, 1'b0);
        idle(2, 1'b0);
        step(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        set_lit(32'd0, 32'd42);
        step(1'b1, 1'b1, 3'd1, 32'd6, 32'd7, 1'b0, 1'b0);
        idle(MC + 1, 1'b0);

        // flush in the second busy cycle of a multiply
        step(1'b1, 1'b1, 3'd1, 32'd9, 32'd9, 1'b0, 1'b0);
        idle(1, 1'b0);
        step(1'b1, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b1);
        idle(MC + 1, 1'b0);

        for (int i = 0; i < 500; i++) begin
            step(($urandom_range(0, 79) == 0) ? 1'b0 : 1'b1,
                 1'($urandom_range(0, 1)),
                 3'($urandom_range(0, 7)),
                 pick(), pick(),
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0);
        end
        idle(DC + 2, 1'b0);
        done = 1'b1;
    end

endmodule
